button_mode_ctrl: RTL and testbench

BUTTON_MODE_CTRL -- requirements
Module: button_mode_ctrl

---
 rtl/watch_pkg.sv | 34 +++
 rtl/btn_debounce.sv | 50 +++++
 rtl/button_mode_ctrl.sv | 118 +++++++++++
 tb/tb_button_mode_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/watch_pkg.sv
// Shared definitions for the button/mode controller: mode encoding, counter
// widths and the button index map used by the top level.
package watch_pkg;

  typedef enum logic [2:0] {
    WATCH     = 3'd0,
    STOPWATCH = 3'd1,
    ALARM     = 3'd2,
    DAY       = 3'd3
  } mode_e;

  // 8 bits covers the full DB_CYCLES range of 2..255.
  localparam int DB_CNT_W  = 8;
  localparam int RPT_CNT_W = 16;

  localparam int NUM_BTN   = 7;
  localparam int BTN_MODE  = 0;
  localparam int BTN_SET   = 1;
  localparam int BTN_RESET = 2;
  localparam int BTN_UP    = 3;
  localparam int BTN_NEXT  = 4;
  localparam int BTN_START = 5;
  localparam int BTN_STOP  = 6;

  function automatic mode_e next_mode(input mode_e m);
    case (m)
      WATCH:     return STOPWATCH;
      STOPWATCH: return ALARM;
      ALARM:     return DAY;
      default:   return WATCH;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One raw button: 2-flop synchronizer, stability counter, debounced level and
// a single-cycle pulse on each accepted 0->1 change.
module btn_debounce
  import watch_pkg::*;
#(
  parameter int DB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic level_o,
  output logic press_o
);

  logic                sync1_q;
  logic                sync2_q;
  logic                level_q;
  logic                press_q;
  logic [DB_CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      press_q <= 1'b0;
      // The level flips on the DB_CYCLES-th consecutive mismatch; any agreement restarts the count.
      if (sync2_q != level_q) begin
        if (cnt_q == DB_CNT_W'(DB_CYCLES - 1)) begin
          level_q <= sync2_q;
          press_q <= sync2_q;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + DB_CNT_W'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/button_mode_ctrl.sv
// Watch front panel: debounces seven buttons, runs the mode/set-entry FSM and
// emits registered command pulses. Optional upTime auto-repeat: BUTTON_AUTO_REPEAT_EN.
// mode | WATCH=0 time display, STOPWATCH=1 timing, ALARM=2 alarm edit, DAY=3 date edit
module button_mode_ctrl
  import watch_pkg::*;
#(
  parameter int DB_CYCLES  = 16,
  parameter int RPT_DELAY  = 64,
  parameter int RPT_PERIOD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btnMode,
  input  logic       btnSet,
  input  logic       btnReset,
  input  logic       btnUp,
  input  logic       btnNext,
  input  logic       btnStart,
  input  logic       btnStop,
  output logic [2:0] mode,
  output logic       setValue,
  output logic       resetTime,
  output logic       upTime,
  output logic       nextd,
  output logic       start_resume,
  output logic       stop
);

  logic [NUM_BTN-1:0] raw;
  logic [NUM_BTN-1:0] lvl;
  logic [NUM_BTN-1:0] press;

  assign raw = {btnStop, btnStart, btnNext, btnUp, btnReset, btnSet, btnMode};

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_db
    btn_debounce #(
      .DB_CYCLES(DB_CYCLES)
    ) u_db (
      .clk    (clk),
      .rst_n  (rst_n),
      .btn_i  (raw[gi]),
      .level_o(lvl[gi]),
      .press_o(press[gi])
    );
  end

  // Only the Up level feeds the repeat logic; the other levels are kept for observability.
  logic unused_lvl;
  assign unused_lvl = ^lvl;

  mode_e mode_q;
  logic  set_q;
  logic  reset_time_q;
  logic  up_time_q;
  logic  nextd_q;
  logic  start_q;
  logic  stop_q;
  logic  rpt_fire;

`ifdef BUTTON_AUTO_REPEAT_EN
  logic [RPT_CNT_W-1:0] rpt_cnt_q;

  // Counter is held at the initial delay whenever repeating is not allowed, so a
  // release or set-entry exit cancels the next pulse immediately.
  assign rpt_fire = lvl[BTN_UP] & set_q & ~press[BTN_UP] & (rpt_cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_cnt_q <= '0;
    end else if (press[BTN_UP] || !(lvl[BTN_UP] && set_q)) begin
      rpt_cnt_q <= RPT_CNT_W'(RPT_DELAY - 1);
    end else if (rpt_cnt_q == '0) begin
      rpt_cnt_q <= RPT_CNT_W'(RPT_PERIOD - 1);
    end else begin
      rpt_cnt_q <= rpt_cnt_q - RPT_CNT_W'(1);
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q       <= WATCH;
      set_q        <= 1'b0;
      reset_time_q <= 1'b0;
      up_time_q    <= 1'b0;
      nextd_q      <= 1'b0;
      start_q      <= 1'b0;
      stop_q       <= 1'b0;
    end else begin
      reset_time_q <= press[BTN_RESET];
      up_time_q    <= press[BTN_UP] | rpt_fire;
      nextd_q      <= press[BTN_NEXT] & set_q;
      stop_q       <= press[BTN_STOP];
      start_q      <= press[BTN_START] & ~press[BTN_STOP];
      // Mode press has priority: it leaves set-entry first, and only advances when not editing.
      if (press[BTN_MODE]) begin
        if (set_q) begin
          set_q <= 1'b0;
        end else begin
          mode_q <= next_mode(mode_q);
        end
      end else if (press[BTN_SET] && (mode_q != STOPWATCH)) begin
        set_q <= ~set_q;
      end
    end
  end

  assign mode         = mode_q;
  assign setValue     = set_q;
  assign resetTime    = reset_time_q;
  assign upTime       = up_time_q;
  assign nextd        = nextd_q;
  assign start_resume = start_q;
  assign stop         = stop_q;

endmodule

// File: tb/tb_button_mode_ctrl.sv
// Directed bench for button_mode_ctrl with default parameters (16/64/16).
// Expectations for upTime follow BUTTON_AUTO_REPEAT_EN when it is defined.
module tb_button_mode_ctrl;

  localparam int LAT = 19;

  logic       clk;
  logic       rst_n;
  logic [6:0] raw;
  logic [2:0] mode;
  logic       setValue, resetTime, upTime, nextd, start_resume, stop;

  int errors = 0;
  int checks = 0;

  logic [4:0] obs_hist  [1:300];
  logic [2:0] mode_hist [1:300];
  logic       set_hist  [1:300];

  button_mode_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btnMode     (raw[0]),
    .btnSet      (raw[1]),
    .btnReset    (raw[2]),
    .btnUp       (raw[3]),
    .btnNext     (raw[4]),
    .btnStart    (raw[5]),
    .btnStop     (raw[6]),
    .mode        (mode),
    .setValue    (setValue),
    .resetTime   (resetTime),
    .upTime      (upTime),
    .nextd       (nextd),
    .start_resume(start_resume),
    .stop        (stop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive mask for hold cycles, then release; records outputs after each edge.
  // obs bits: 4 stop, 3 start_resume, 2 nextd, 1 upTime, 0 resetTime
  task automatic hold_btns(input logic [6:0] mask, input int hold, input int tail);
    raw = mask;
    for (int k = 1; k <= hold + tail; k++) begin
      step();
      obs_hist[k]  = {stop, start_resume, nextd, upTime, resetTime};
      mode_hist[k] = mode;
      set_hist[k]  = setValue;
      if (k == hold) raw = '0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    raw   = '0;
    repeat (3) step();
    checks++;
    if (mode !== 3'd0) begin errors++; $display("FAIL reset_mode: got %0d expected 0", mode); end
    checks++;
    if (setValue !== 1'b0) begin errors++; $display("FAIL reset_set: got %0b expected 0", setValue); end
    checks++;
    if ({stop, start_resume, nextd, upTime, resetTime} !== 5'b0) begin
      errors++; $display("FAIL reset_pulses: got %b expected 00000", {stop, start_resume, nextd, upTime, resetTime});
    end
    rst_n = 1'b1;
    repeat (5) step();
    checks++;
    if (mode !== 3'd0) begin errors++; $display("FAIL idle_mode: got %0d expected 0", mode); end
  endtask

  task automatic test_mode_cycle();
    for (int p = 0; p < 4; p++) begin
      hold_btns(7'b0000001, 40, 25);
      checks++;
      if (mode_hist[LAT-1] !== 3'(p)) begin
        errors++; $display("FAIL mode_early p%0d: got %0d expected %0d", p, mode_hist[LAT-1], p);
      end
      checks++;
      if (mode_hist[LAT] !== 3'((p + 1) % 4)) begin
        errors++; $display("FAIL mode_step p%0d: got %0d expected %0d", p, mode_hist[LAT], (p + 1) % 4);
      end
      checks++;
      if (mode_hist[65] !== 3'((p + 1) % 4)) begin
        errors++; $display("FAIL mode_release p%0d: got %0d expected %0d", p, mode_hist[65], (p + 1) % 4);
      end
    end
  endtask

  task automatic test_set_bounce();
    int   toggles;
    logic prev;
    toggles = 0;
    prev    = setValue;
    for (int i = 0; i < 30; i++) begin
      raw[1] = ((i / 5) % 2) == 0;
      step();
      if (setValue !== prev) toggles++;
      prev = setValue;
    end
    raw[1] = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (setValue !== prev) toggles++;
      prev = setValue;
      if (k == LAT - 1) begin
        checks++;
        if (setValue !== 1'b0) begin errors++; $display("FAIL bounce_early: got %0b expected 0", setValue); end
      end
      if (k == LAT) begin
        checks++;
        if (setValue !== 1'b1) begin errors++; $display("FAIL bounce_toggle: got %0b expected 1", setValue); end
      end
    end
    raw[1] = 1'b0;
    repeat (25) step();
    checks++;
    if (toggles != 1) begin errors++; $display("FAIL bounce_count: got %0d toggles expected 1", toggles); end
    checks++;
    if (setValue !== 1'b1) begin errors++; $display("FAIL bounce_release: got %0b expected 1", setValue); end
  endtask

  task automatic test_auto_repeat();
    int   cnt;
    logic exp_bit;
    cnt = 0;
    hold_btns(7'b0001000, 200, 60);
    for (int k = 1; k <= 260; k++) begin
`ifdef BUTTON_AUTO_REPEAT_EN
      exp_bit = (k == LAT) || (k >= 83 && k <= 218 && ((k - 83) % 16) == 0);
`else
      exp_bit = (k == LAT);
`endif
      if (obs_hist[k][1] === 1'b1) cnt++;
      checks++;
      if (obs_hist[k][1] !== exp_bit) begin
        errors++; $display("FAIL uptime_k%0d: got %b expected %b", k, obs_hist[k][1], exp_bit);
      end
    end
    checks++;
`ifdef BUTTON_AUTO_REPEAT_EN
    if (cnt != 10) begin errors++; $display("FAIL uptime_count: got %0d expected 10", cnt); end
`else
    if (cnt != 1) begin errors++; $display("FAIL uptime_count: got %0d expected 1", cnt); end
`endif
  endtask

  task automatic test_commands();
    hold_btns(7'b0010000, 30, 25);
    for (int k = 1; k <= 55; k++) begin
      checks++;
      if (obs_hist[k][2] !== (k == LAT)) begin
        errors++; $display("FAIL nextd_k%0d: got %b expected %b", k, obs_hist[k][2], (k == LAT));
      end
    end
    hold_btns(7'b0000100, 30, 25);
    for (int k = 1; k <= 55; k++) begin
      checks++;
      if (obs_hist[k][0] !== (k == LAT)) begin
        errors++; $display("FAIL reset_time_k%0d: got %b expected %b", k, obs_hist[k][0], (k == LAT));
      end
    end
    hold_btns(7'b0100000, 30, 25);
    for (int k = 1; k <= 55; k++) begin
      checks++;
      if (obs_hist[k][3] !== (k == LAT)) begin
        errors++; $display("FAIL start_k%0d: got %b expected %b", k, obs_hist[k][3], (k == LAT));
      end
    end
  endtask

  task automatic test_start_stop();
    int n_stop, n_start;
    n_stop  = 0;
    n_start = 0;
    hold_btns(7'b1100000, 30, 25);
    for (int k = 1; k <= 55; k++) begin
      if (obs_hist[k][4] === 1'b1) n_stop++;
      if (obs_hist[k][3] === 1'b1) n_start++;
    end
    checks++;
    if (n_stop != 1) begin errors++; $display("FAIL both_stop_count: got %0d expected 1", n_stop); end
    checks++;
    if (obs_hist[LAT][4] !== 1'b1) begin errors++; $display("FAIL both_stop_time: got %b expected 1", obs_hist[LAT][4]); end
    checks++;
    if (n_start != 0) begin errors++; $display("FAIL both_start_count: got %0d expected 0", n_start); end
  endtask

  task automatic test_next_suppressed();
    int n_next;
    n_next = 0;
    hold_btns(7'b0000010, 30, 25);
    checks++;
    if (set_hist[LAT - 1] !== 1'b1 || set_hist[LAT] !== 1'b0) begin
      errors++; $display("FAIL set_clear: got %b%b expected 10", set_hist[LAT - 1], set_hist[LAT]);
    end
    hold_btns(7'b0010000, 30, 25);
    for (int k = 1; k <= 55; k++) if (obs_hist[k][2] === 1'b1) n_next++;
    checks++;
    if (n_next != 0) begin errors++; $display("FAIL nextd_suppressed: got %0d pulses expected 0", n_next); end
  endtask

  task automatic test_stopwatch_set();
    int n_set;
    n_set = 0;
    hold_btns(7'b0000001, 30, 25);
    checks++;
    if (mode !== 3'd1) begin errors++; $display("FAIL to_stopwatch: got %0d expected 1", mode); end
    hold_btns(7'b0000010, 30, 25);
    for (int k = 1; k <= 55; k++) if (set_hist[k] === 1'b1) n_set++;
    checks++;
    if (n_set != 0) begin errors++; $display("FAIL stopwatch_set: got %0d high cycles expected 0", n_set); end
  endtask

  task automatic test_alarm();
    hold_btns(7'b0000001, 30, 25);
    checks++;
    if (mode !== 3'd2) begin errors++; $display("FAIL to_alarm: got %0d expected 2", mode); end
    hold_btns(7'b0000010, 30, 25);
    checks++;
    if (setValue !== 1'b1) begin errors++; $display("FAIL alarm_set: got %0b expected 1", setValue); end
    hold_btns(7'b0000001, 30, 25);
    checks++;
    if (set_hist[LAT] !== 1'b0 || mode_hist[LAT] !== 3'd2) begin
      errors++; $display("FAIL alarm_exit_set: got mode %0d set %b expected mode 2 set 0", mode_hist[LAT], set_hist[LAT]);
    end
    hold_btns(7'b0000001, 30, 25);
    checks++;
    if (mode !== 3'd3) begin errors++; $display("FAIL to_day: got %0d expected 3", mode); end
    hold_btns(7'b0000011, 30, 25);
    checks++;
    if (mode !== 3'd0 || setValue !== 1'b0) begin
      errors++; $display("FAIL mode_set_same: got mode %0d set %b expected mode 0 set 0", mode, setValue);
    end
    hold_btns(7'b0000001, 30, 25);
    hold_btns(7'b0000001, 30, 25);
    hold_btns(7'b0000010, 30, 25);
  endtask

  task automatic test_reset_mid();
    int changes;
    changes = 0;
    checks++;
    if (mode !== 3'd2 || setValue !== 1'b1) begin
      errors++; $display("FAIL premid_state: got mode %0d set %b expected mode 2 set 1", mode, setValue);
    end
    raw = 7'b0000001;
    repeat (8) step();
    rst_n = 1'b0;
    step();
    checks++;
    if (mode !== 3'd0 || setValue !== 1'b0) begin
      errors++; $display("FAIL mid_reset_state: got mode %0d set %b expected mode 0 set 0", mode, setValue);
    end
    raw = '0;
    repeat (2) step();
    rst_n = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (mode !== 3'd0 || {stop, start_resume, nextd, upTime, resetTime} !== 5'b0) changes++;
    end
    checks++;
    if (changes != 0) begin errors++; $display("FAIL mid_reset_event: got %0d active cycles expected 0", changes); end
  endtask

  task automatic test_held_through_reset();
    raw   = 7'b0000001;
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (k == LAT - 1) begin
        checks++;
        if (mode !== 3'd0) begin errors++; $display("FAIL held_early: got %0d expected 0", mode); end
      end
      if (k == LAT) begin
        checks++;
        if (mode !== 3'd1) begin errors++; $display("FAIL held_press: got %0d expected 1", mode); end
      end
    end
    raw = '0;
    repeat (25) step();
  endtask

  initial begin
    rst_n = 1'b0;
    raw   = '0;
    test_reset();
    test_mode_cycle();
    test_set_bounce();
    test_auto_repeat();
    test_commands();
    test_start_stop();
    test_next_suppressed();
    test_stopwatch_set();
    test_alarm();
    test_reset_mid();
    test_held_through_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
